clock_timekeeper: RTL and testbench

CLOCK_TIMEKEEPER -- requirements
Module: clock_timekeeper

---
 rtl/vga_clock_pkg.sv | 63 ++++++
 rtl/bcd_digit_counter.sv | 35 +++
 rtl/clock_timekeeper.sv | 132 +++++++++++++
 tb/tb_clock_timekeeper.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_clock_pkg.sv
// Shared definitions for the pixel-clock timekeeper: digit limits, the
// load_time field layout, the time record and the update-source encoding.
package vga_clock_pkg;

  localparam logic [3:0] UNIT_MAX  = 4'd9;
  localparam logic [2:0] SEC_D_MAX = 3'd5;
  localparam logic [2:0] MIN_D_MAX = 3'd5;

  // load_time = {pm, hrs_d[1:0], hrs_u[3:0], min_d[2:0], min_u[3:0], sec_d[2:0], sec_u[3:0]}
  localparam int unsigned LT_W     = 21;
  localparam int unsigned LT_SEC_U = 0;
  localparam int unsigned LT_SEC_D = 4;
  localparam int unsigned LT_MIN_U = 7;
  localparam int unsigned LT_MIN_D = 11;
  localparam int unsigned LT_HRS_U = 14;
  localparam int unsigned LT_HRS_D = 18;
  localparam int unsigned LT_PM    = 20;

  typedef struct packed {
    logic       pm;
    logic [1:0] hrs_d;
    logic [3:0] hrs_u;
    logic [2:0] min_d;
    logic [3:0] min_u;
    logic [2:0] sec_d;
    logic [3:0] sec_u;
  } time_t;

  // Which event owns the current cycle's time update, highest priority first.
  typedef enum logic [1:0] {
    UPD_IDLE,
    UPD_LOAD,
    UPD_ADJUST,
    UPD_TICK
  } upd_src_e;

  function automatic time_t unpack_time(input logic [LT_W-1:0] v);
    time_t t;
    t.sec_u = v[LT_SEC_U +: 4];
    t.sec_d = v[LT_SEC_D +: 3];
    t.min_u = v[LT_MIN_U +: 4];
    t.min_d = v[LT_MIN_D +: 3];
    t.hrs_u = v[LT_HRS_U +: 4];
    t.hrs_d = v[LT_HRS_D +: 2];
    t.pm    = v[LT_PM];
    return t;
  endfunction

  // Digit and hour-range check for a requested load; pm is not range-checked.
  function automatic logic time_valid(input time_t t, input logic h24);
    logic ok;
    ok = (t.sec_u <= UNIT_MAX) && (t.sec_d <= SEC_D_MAX) &&
         (t.min_u <= UNIT_MAX) && (t.min_d <= MIN_D_MAX) &&
         (t.hrs_u <= UNIT_MAX);
    if (h24)
      ok = ok && ((t.hrs_d < 2'd2) || ((t.hrs_d == 2'd2) && (t.hrs_u <= 4'd3)));
    else
      ok = ok && (((t.hrs_d == 2'd0) && (t.hrs_u != 4'd0)) ||
                  ((t.hrs_d == 2'd1) && (t.hrs_u <= 4'd2)));
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: wraps MAX -> 0 on inc, parallel load overrides inc,
// carry is high in the cycle an inc will wrap the digit.
module bcd_digit_counter #(
  parameter int unsigned W       = 4,
  parameter int unsigned MAX     = 9,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         px_clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         carry
);

  localparam logic [W-1:0] QMAX = W'(MAX);
  localparam logic [W-1:0] QRST = W'(RST_VAL);

  // Carry out to the next digit when this one rolls over.
  always_comb begin
    carry = inc && (q == QMAX);
  end

  // Digit register: reset, then load, then increment.
  always_ff @(posedge px_clk) begin
    if (reset)
      q <= QRST;
    else if (load)
      q <= load_val;
    else if (inc)
      q <= (q == QMAX) ? '0 : q + 1'b1;
  end

endmodule

// File: rtl/clock_timekeeper.sv
// Time-of-day keeper running off the pixel clock: prescaled one-second
// tick, BCD digit chain, 12/24-hour handling, adjust/load and palette rotation.
module clock_timekeeper
  import vga_clock_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 31_500_000,
  parameter int unsigned H24     = 1,
  parameter int unsigned COLOR_W = 4
) (
  input  logic               px_clk,
  input  logic               reset,
  input  logic               adj_sec,
  input  logic               adj_min,
  input  logic               adj_hrs,
  input  logic               load,
  input  logic [LT_W-1:0]    load_time,
  output logic [3:0]         sec_u,
  output logic [2:0]         sec_d,
  output logic [3:0]         min_u,
  output logic [2:0]         min_d,
  output logic [3:0]         hrs_u,
  output logic [1:0]         hrs_d,
  output logic               pm,
  output logic               sec_tick,
  output logic               min_tick,
  output logic               load_err,
  output logic [COLOR_W-1:0] color_offset
);

  localparam logic        MODE24  = (H24 != 0);
  localparam int unsigned PW      = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] prescaler;
  logic          tick;
  time_t         ld;
  logic          ld_valid;
  upd_src_e      src;
  logic          ld_en, adj_en, tick_adv;
  logic          sec_step, min_step, hr_step, hr_wrap, pm_toggle;
  logic          c_su, c_sd, c_mu, c_md, c_hu;
  logic          hrs_d_carry_unused;
  logic          hrs_load;
  logic [3:0]    hrs_u_load_val;
  logic [1:0]    hrs_d_load_val;

  // Decode the load word and pick the single event that owns this cycle.
  // A rejected load is dropped entirely, so adjust/tick proceed as usual.
  always_comb begin
    ld       = unpack_time(load_time);
    ld_valid = time_valid(ld, MODE24);
    tick     = (prescaler == PS_LAST);
    src      = UPD_IDLE;
    if (load && ld_valid)
      src = UPD_LOAD;
    else if (adj_sec || adj_min || adj_hrs)
      src = UPD_ADJUST;
    else if (tick)
      src = UPD_TICK;
    ld_en    = (src == UPD_LOAD);
    adj_en   = (src == UPD_ADJUST);
    tick_adv = (src == UPD_TICK);
  end

  // Field step enables; adjusts never propagate carries into the next field.
  always_comb begin
    sec_step  = tick_adv || (adj_en && adj_sec);
    min_step  = (tick_adv && c_sd) || (adj_en && adj_min);
    hr_step   = (tick_adv && c_md) || (adj_en && adj_hrs);
    hr_wrap   = hr_step && (MODE24 ? ((hrs_d == 2'd2) && (hrs_u == 4'd3))
                                   : ((hrs_d == 2'd1) && (hrs_u == 4'd2)));
    pm_toggle = !MODE24 && hr_step && (hrs_d == 2'd1) && (hrs_u == 4'd1);
    // Hour wrap (23->00 or 12->01) is applied as a load of both hour digits.
    hrs_load       = ld_en || hr_wrap;
    hrs_u_load_val = ld_en ? ld.hrs_u : (MODE24 ? 4'd0 : 4'd1);
    hrs_d_load_val = ld_en ? ld.hrs_d : 2'd0;
  end

  bcd_digit_counter #(.W(4), .MAX(int'(UNIT_MAX)), .RST_VAL(0)) u_sec_u (
    .px_clk(px_clk), .reset(reset), .inc(sec_step), .load(ld_en),
    .load_val(ld.sec_u), .q(sec_u), .carry(c_su));

  bcd_digit_counter #(.W(3), .MAX(int'(SEC_D_MAX)), .RST_VAL(0)) u_sec_d (
    .px_clk(px_clk), .reset(reset), .inc(c_su), .load(ld_en),
    .load_val(ld.sec_d), .q(sec_d), .carry(c_sd));

  bcd_digit_counter #(.W(4), .MAX(int'(UNIT_MAX)), .RST_VAL(0)) u_min_u (
    .px_clk(px_clk), .reset(reset), .inc(min_step), .load(ld_en),
    .load_val(ld.min_u), .q(min_u), .carry(c_mu));

  bcd_digit_counter #(.W(3), .MAX(int'(MIN_D_MAX)), .RST_VAL(0)) u_min_d (
    .px_clk(px_clk), .reset(reset), .inc(c_mu), .load(ld_en),
    .load_val(ld.min_d), .q(min_d), .carry(c_md));

  bcd_digit_counter #(.W(4), .MAX(int'(UNIT_MAX)), .RST_VAL(MODE24 ? 0 : 2)) u_hrs_u (
    .px_clk(px_clk), .reset(reset), .inc(hr_step && !hr_wrap), .load(hrs_load),
    .load_val(hrs_u_load_val), .q(hrs_u), .carry(c_hu));

  bcd_digit_counter #(.W(2), .MAX(2), .RST_VAL(MODE24 ? 0 : 1)) u_hrs_d (
    .px_clk(px_clk), .reset(reset), .inc(c_hu), .load(hrs_load),
    .load_val(hrs_d_load_val), .q(hrs_d), .carry(hrs_d_carry_unused));

  // Prescaler: restarts on reset and on an accepted load, wraps at CLK_HZ-1.
  always_ff @(posedge px_clk) begin
    if (reset || ld_en || tick)
      prescaler <= '0;
    else
      prescaler <= prescaler + 1'b1;
  end

  // pm flag, palette rotation and single-cycle strobes.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      pm           <= 1'b0;
      color_offset <= '0;
      sec_tick     <= 1'b0;
      min_tick     <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      if (ld_en)
        pm <= MODE24 ? 1'b0 : ld.pm;
      else if (pm_toggle)
        pm <= ~pm;
      if (min_step)
        color_offset <= color_offset + 1'b1;
      sec_tick <= tick_adv;
      min_tick <= tick_adv && c_sd;
      load_err <= load && !ld_valid;
    end
  end

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench: one 24-hour and one 12-hour instance at CLK_HZ=4 sharing
// stimulus; the instance not under test is held in reset.
module tb_clock_timekeeper;

  logic        px_clk = 1'b0;
  logic        rst24, rst12;
  logic        adj_sec, adj_min, adj_hrs, load;
  logic [20:0] load_time;

  logic [3:0] su24, mu24, hu24, su12, mu12, hu12;
  logic [2:0] sd24, md24, sd12, md12;
  logic [1:0] hd24, hd12;
  logic       pm24, st24, mt24, le24, pm12, st12, mt12, le12;
  logic [3:0] col24, col12;
  logic [20:0] tm24, tm12;

  int checks = 0;
  int fails  = 0;

  always #5 px_clk = ~px_clk;

  assign tm24 = {pm24, hd24, hu24, md24, mu24, sd24, su24};
  assign tm12 = {pm12, hd12, hu12, md12, mu12, sd12, su12};

  clock_timekeeper #(.CLK_HZ(4), .H24(1), .COLOR_W(4)) dut24 (
    .px_clk(px_clk), .reset(rst24), .adj_sec(adj_sec), .adj_min(adj_min),
    .adj_hrs(adj_hrs), .load(load), .load_time(load_time),
    .sec_u(su24), .sec_d(sd24), .min_u(mu24), .min_d(md24), .hrs_u(hu24),
    .hrs_d(hd24), .pm(pm24), .sec_tick(st24), .min_tick(mt24),
    .load_err(le24), .color_offset(col24));

  clock_timekeeper #(.CLK_HZ(4), .H24(0), .COLOR_W(4)) dut12 (
    .px_clk(px_clk), .reset(rst12), .adj_sec(adj_sec), .adj_min(adj_min),
    .adj_hrs(adj_hrs), .load(load), .load_time(load_time),
    .sec_u(su12), .sec_d(sd12), .min_u(mu12), .min_d(md12), .hrs_u(hu12),
    .hrs_d(hd12), .pm(pm12), .sec_tick(st12), .min_tick(mt12),
    .load_err(le12), .color_offset(col12));

  // BCD-encode a wall-clock time in load_time layout.
  function automatic logic [20:0] mk(input logic p, input int h, input int m, input int s);
    return {p, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge px_clk);
  endtask

  task automatic apply_load(input logic [20:0] t);
    load = 1'b1;
    load_time = t;
    @(negedge px_clk);
    load = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic m, input logic h);
    adj_sec = s; adj_min = m; adj_hrs = h;
    @(negedge px_clk);
    adj_sec = 1'b0; adj_min = 1'b0; adj_hrs = 1'b0;
  endtask

  task automatic test_reset;
    rst24 = 1'b1; rst12 = 1'b1;
    cycles(2);
    checks++; if (tm24 !== mk(0, 0, 0, 0)) begin fails++; $display("FAIL reset_time24: got %h want %h", tm24, mk(0, 0, 0, 0)); end
    checks++; if (col24 !== 4'd0) begin fails++; $display("FAIL reset_color24: got %0d want 0", col24); end
    checks++; if ({st24, mt24, le24} !== 3'b000) begin fails++; $display("FAIL reset_strobes24: got %b want 000", {st24, mt24, le24}); end
    checks++; if (tm12 !== mk(0, 12, 0, 0)) begin fails++; $display("FAIL reset_time12: got %h want %h", tm12, mk(0, 12, 0, 0)); end
    rst24 = 1'b0;
  endtask

  task automatic test_rollover24;
    int nmt, nst;
    nmt = 0; nst = 0;
    apply_load(mk(1, 23, 59, 58));
    checks++; if (tm24 !== mk(0, 23, 59, 58)) begin fails++; $display("FAIL load24_pm_ignored: got %h want %h", tm24, mk(0, 23, 59, 58)); end
    for (int i = 1; i <= 8; i++) begin
      cycles(1);
      nmt += int'(mt24); nst += int'(st24);
      if (i == 3) begin
        checks++; if ({tm24, st24} !== {mk(0, 23, 59, 58), 1'b0}) begin fails++; $display("FAIL pre_tick: got %h/%b want %h/0", tm24, st24, mk(0, 23, 59, 58)); end
      end
      if (i == 4) begin
        checks++; if ({tm24, st24, mt24} !== {mk(0, 23, 59, 59), 2'b10}) begin fails++; $display("FAIL tick_59: got %h/%b%b want %h/10", tm24, st24, mt24, mk(0, 23, 59, 59)); end
      end
      if (i == 8) begin
        checks++; if ({tm24, st24, mt24} !== {mk(0, 0, 0, 0), 2'b11}) begin fails++; $display("FAIL midnight: got %h/%b%b want %h/11", tm24, st24, mt24, mk(0, 0, 0, 0)); end
      end
    end
    checks++; if (nmt != 1 || nst != 2) begin fails++; $display("FAIL strobe_count: got min %0d sec %0d want 1 2", nmt, nst); end
    checks++; if (col24 !== 4'd1) begin fails++; $display("FAIL color_tick: got %0d want 1", col24); end
  endtask

  task automatic test_adjust;
    apply_load(mk(0, 10, 59, 30));
    pulse(0, 1, 0);
    checks++; if (tm24 !== mk(0, 10, 0, 30)) begin fails++; $display("FAIL adj_min_wrap: got %h want %h", tm24, mk(0, 10, 0, 30)); end
    checks++; if (col24 !== 4'd2) begin fails++; $display("FAIL color_adj: got %0d want 2", col24); end
    apply_load(mk(0, 10, 20, 59));
    checks++; if (col24 !== 4'd2) begin fails++; $display("FAIL color_load: got %0d want 2", col24); end
    pulse(1, 0, 0);
    checks++; if ({tm24, mt24} !== {mk(0, 10, 20, 0), 1'b0}) begin fails++; $display("FAIL adj_sec_wrap: got %h/%b want %h/0", tm24, mt24, mk(0, 10, 20, 0)); end
    pulse(0, 0, 1);
    checks++; if (tm24 !== mk(0, 11, 20, 0)) begin fails++; $display("FAIL adj_hrs: got %h want %h", tm24, mk(0, 11, 20, 0)); end
    apply_load(mk(0, 23, 20, 0));
    pulse(0, 0, 1);
    checks++; if (tm24 !== mk(0, 0, 20, 0)) begin fails++; $display("FAIL adj_hrs_wrap24: got %h want %h", tm24, mk(0, 0, 20, 0)); end
    pulse(1, 1, 1);
    checks++; if ({tm24, col24} !== {mk(0, 1, 21, 1), 4'd3}) begin fails++; $display("FAIL adj_all: got %h/%0d want %h/3", tm24, col24, mk(0, 1, 21, 1)); end
  endtask

  task automatic test_adj_on_tick;
    apply_load(mk(0, 10, 20, 30));
    cycles(3);
    pulse(1, 0, 0);
    checks++; if ({tm24, st24} !== {mk(0, 10, 20, 31), 1'b0}) begin fails++; $display("FAIL adj_on_tick: got %h/%b want %h/0", tm24, st24, mk(0, 10, 20, 31)); end
    cycles(3);
    checks++; if ({tm24, st24} !== {mk(0, 10, 20, 31), 1'b0}) begin fails++; $display("FAIL no_early_tick: got %h/%b want %h/0", tm24, st24, mk(0, 10, 20, 31)); end
    cycles(1);
    checks++; if ({tm24, st24} !== {mk(0, 10, 20, 32), 1'b1}) begin fails++; $display("FAIL tick_after_adj: got %h/%b want %h/1", tm24, st24, mk(0, 10, 20, 32)); end
  endtask

  task automatic test_load_err24;
    apply_load(mk(0, 24, 0, 0));
    checks++; if ({tm24, le24} !== {mk(0, 10, 20, 32), 1'b1}) begin fails++; $display("FAIL load_err_24h: got %h/%b want %h/1", tm24, le24, mk(0, 10, 20, 32)); end
    apply_load(mk(0, 10, 20, 60));
    checks++; if ({tm24, le24} !== {mk(0, 10, 20, 32), 1'b1}) begin fails++; $display("FAIL load_err_sec: got %h/%b want %h/1", tm24, le24, mk(0, 10, 20, 32)); end
    cycles(1);
    checks++; if (le24 !== 1'b0) begin fails++; $display("FAIL load_err_pulse: got %b want 0", le24); end
  endtask

  task automatic test_reset_midcount;
    apply_load(mk(0, 10, 20, 30));
    checks++; if ({tm24, st24} !== {mk(0, 10, 20, 30), 1'b0}) begin fails++; $display("FAIL load_value: got %h/%b want %h/0", tm24, st24, mk(0, 10, 20, 30)); end
    cycles(2);
    rst24 = 1'b1;
    cycles(1);
    checks++; if ({tm24, col24, st24} !== {mk(0, 0, 0, 0), 4'd0, 1'b0}) begin fails++; $display("FAIL reset_mid: got %h/%0d/%b want %h/0/0", tm24, col24, st24, mk(0, 0, 0, 0)); end
    rst24 = 1'b0;
    cycles(3);
    checks++; if ({tm24, st24} !== {mk(0, 0, 0, 0), 1'b0}) begin fails++; $display("FAIL partial_discard: got %h/%b want %h/0", tm24, st24, mk(0, 0, 0, 0)); end
    cycles(1);
    checks++; if ({tm24, st24} !== {mk(0, 0, 0, 1), 1'b1}) begin fails++; $display("FAIL first_tick: got %h/%b want %h/1", tm24, st24, mk(0, 0, 0, 1)); end
    rst24 = 1'b1;
  endtask

  task automatic test_12h;
    rst12 = 1'b0;
    apply_load(mk(0, 11, 59, 59));
    cycles(4);
    checks++; if ({tm12, mt12} !== {mk(1, 12, 0, 0), 1'b1}) begin fails++; $display("FAIL noon_pm: got %h/%b want %h/1", tm12, mt12, mk(1, 12, 0, 0)); end
    apply_load(mk(1, 12, 59, 59));
    cycles(4);
    checks++; if (tm12 !== mk(1, 1, 0, 0)) begin fails++; $display("FAIL wrap12: got %h want %h", tm12, mk(1, 1, 0, 0)); end
    apply_load(mk(1, 11, 5, 0));
    pulse(0, 0, 1);
    checks++; if (tm12 !== mk(0, 12, 5, 0)) begin fails++; $display("FAIL adj_hrs_pm: got %h want %h", tm12, mk(0, 12, 5, 0)); end
    pulse(0, 0, 1);
    checks++; if (tm12 !== mk(0, 1, 5, 0)) begin fails++; $display("FAIL adj_hrs_wrap12: got %h want %h", tm12, mk(0, 1, 5, 0)); end
    apply_load(mk(0, 9, 5, 0));
    pulse(0, 0, 1);
    checks++; if (tm12 !== mk(0, 10, 5, 0)) begin fails++; $display("FAIL adj_hrs_9_10: got %h want %h", tm12, mk(0, 10, 5, 0)); end
    apply_load(mk(0, 0, 10, 0));
    checks++; if ({tm12, le12} !== {mk(0, 10, 5, 0), 1'b1}) begin fails++; $display("FAIL load_err_00h: got %h/%b want %h/1", tm12, le12, mk(0, 10, 5, 0)); end
    apply_load(mk(0, 13, 0, 0));
    checks++; if ({tm12, le12} !== {mk(0, 10, 5, 0), 1'b1}) begin fails++; $display("FAIL load_err_13h: got %h/%b want %h/1", tm12, le12, mk(0, 10, 5, 0)); end
    checks++; if (col12 !== 4'd2) begin fails++; $display("FAIL color12: got %0d want 2", col12); end
  endtask

  initial begin
    adj_sec = 1'b0; adj_min = 1'b0; adj_hrs = 1'b0;
    load = 1'b0; load_time = '0;
    test_reset();
    test_rollover24();
    test_adjust();
    test_adj_on_tick();
    test_load_err24();
    test_reset_midcount();
    test_12h();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
